sar_conv_sequencer: RTL and testbench
=====================================

// Module: sar_conv_sequencer
// PURPOSE
//  Parametrised SAR ADC conversion sequencer; next generation of clk_gen.
//  Generates sample/compare phases and runs the successive-approximation register, MSB first.
//  Adds multi-channel round-robin, continuous mode and a comparator-timeout abort.
//  Sits between the external clock domain, the comparator and the DAC/output register.
// PARAMETERS
//  NUM_BITS       4   conversion resolution, legal range 2..16
//  SAMPLE_CYCLES  2   cycles clk_sample is held high, must be >= 1
//  NUM_CH         1   number of input channels, 1..8, round-robin
//  TIMEOUT_CYCLES 16  max cycles to wait for comp_ready per bit, >= 2
// PORTS
//  clk_external  in   1                  sole clock, rising edge
//  reset         in   1                  synchronous, active-high
//  start         in   1                  conversion request, sampled only while ready=1
//  cont          in   1                  1 = continuous mode, re-convert next channel after DONE
//  comp_ready    in   1                  comparator decision strobe, 1-cycle pulse, already synchronous
//  comp_out      in   1                  comparator result, 1 = vin >= DAC; valid when comp_ready=1
//  clk_sample    out  1                  sample switch enable
//  register_clk  out  1                  output-register load strobe
//  ready         out  1                  idle, start accepted
//  busy          out  1                  conversion in progress
//  dac_code      out  NUM_BITS           trial code driven to the DAC
//  ch_sel        out  $clog2(NUM_CH)|1   channel being converted
//  sar_code      out  NUM_BITS           last completed result, held
//  data_valid    out  1                  1-cycle pulse, sar_code/ch_id updated
//  ch_id         out  $clog2(NUM_CH)|1   channel of sar_code
//  err_timeout   out  1                  1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (sync): state=IDLE, ready=1, all other outputs 0, ch_sel=0.
//  States: IDLE -> SAMPLE -> COMPARE -> DONE -> (IDLE | SAMPLE).
//  IDLE
//   - ready=1, busy=0.
//   - start=1 -> SAMPLE next cycle.
//  SAMPLE
//   - clk_sample=1 for exactly SAMPLE_CYCLES cycles.
//   - dac_code=0, bit index i=NUM_BITS-1.
//   - Then -> COMPARE.
//  COMPARE
//   - First cycle: dac_code = 1<<i.
//   - On comp_ready: bit i kept if comp_out=1, cleared if 0; i--; next bit set in the same update.
//   - Comparator model sees the new dac_code one cycle after the strobe.
//   - After the NUM_BITS-th comp_ready -> DONE.
//   - comp_ready outside COMPARE is ignored.
//  DONE (1 cycle)
//   - register_clk=1, data_valid=1, sar_code=final dac_code, ch_id=ch_sel.
//   - ch_sel increments, wrapping NUM_CH-1 -> 0.
//   - cont=1 -> SAMPLE, else -> IDLE.
//  Latency: start at cycle 0 -> clk_sample high cycles 1..S -> COMPARE from cycle S+1.
//   - data_valid arrives one cycle after the last comp_ready.
//  Timeout
//   - Per-bit counter clears on entry to COMPARE and on each comp_ready.
//   - Reaching TIMEOUT_CYCLES: err_timeout pulse, -> IDLE.
//   - sar_code, ch_id and ch_sel unchanged; no data_valid.
//  Boundary cases
//   - start while busy: ignored.
//   - cont deasserted mid-conversion: current conversion finishes, then IDLE.
//   - comp_ready in the same cycle the timeout expires: comp_ready wins, counter clears.
//   - reset mid-conversion: next cycle is IDLE, partial code discarded, sar_code=0.
//   - NUM_CH=1: ch_sel and ch_id are constant 0.
// STRUCTURE
//  Package sar_pkg:
//   - typedef enum logic [1:0] {IDLE, SAMPLE, COMPARE, DONE} sar_state_t.
//   - Parameter legality localparams.
//  Sub-module sar_bit_register: trial/keep/clear logic, index i, dac_code.
//   - Ports: load_init, strobe, decision.
//  Top holds: FSM, sample counter, timeout counter, channel counter, output registers.
// TESTING
//  T1: NUM_BITS=4, vin=9, comparator model 2-cycle latency
//      -> dac_code 8,12,10,9; sar_code=9 (1001), one data_valid.
//  T2: vin=0 and vin=15 -> sar_code 0 and 15; all trial codes checked.
//  T3: NUM_CH=3, cont=1, vins {3,7,12}, run 4 conversions
//      -> ch_id 0,1,2,0; codes 3,7,12,3; no IDLE cycle between conversions.
//  T4: TIMEOUT_CYCLES=16, comp_ready withheld after bit 2
//      -> err_timeout pulse 16 cycles after the last strobe; ready=1 next cycle; sar_code unchanged.
//  T5: reset asserted mid-COMPARE
//      -> next cycle ready=1, dac_code=0, sar_code=0; start then converts normally.
//  T6: start pulsed during SAMPLE/COMPARE; SAMPLE_CYCLES=3
//      -> ignored; clk_sample high exactly 3 cycles per conversion.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types, parameter limits and helpers for the SAR conversion sequencer.
package sar_pkg;

   typedef enum logic [1:0] {IDLE, SAMPLE, COMPARE, DONE} sar_state_t;

   localparam int unsigned MIN_NUM_BITS       = 2;
   localparam int unsigned MAX_NUM_BITS       = 16;
   localparam int unsigned MIN_SAMPLE_CYCLES  = 1;
   localparam int unsigned MIN_NUM_CH         = 1;
   localparam int unsigned MAX_NUM_CH         = 8;
   localparam int unsigned MIN_TIMEOUT_CYCLES = 2;

   // Width of a channel index; a single channel still gets one (constant) bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit params_legal(input int unsigned num_bits,
                                       input int unsigned sample_cycles,
                                       input int unsigned num_ch,
                                       input int unsigned timeout_cycles);
      return (num_bits >= MIN_NUM_BITS) && (num_bits <= MAX_NUM_BITS) &&
             (sample_cycles >= MIN_SAMPLE_CYCLES) &&
             (num_ch >= MIN_NUM_CH) && (num_ch <= MAX_NUM_CH) &&
             (timeout_cycles >= MIN_TIMEOUT_CYCLES);
   endfunction

endpackage

// File: rtl/sar_bit_register.sv
// Successive-approximation register: MSB-first trial, keep/clear and bit index.
module sar_bit_register #(
   parameter int unsigned NUM_BITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_init,
   input  logic                set_trial,
   input  logic                strobe,
   input  logic                decision,
   output logic [NUM_BITS-1:0] code,
   output logic                last_c
);

   localparam int unsigned IW = $clog2(NUM_BITS);

   logic [IW-1:0] idx;

   // Clear for a new sample, place the first trial bit, then resolve one bit per strobe.
   always_ff @(posedge clk) begin
      if (reset || load_init) begin
         code <= '0;
         idx  <= IW'(NUM_BITS - 1);
      end else if (set_trial) begin
         code[idx] <= 1'b1;
      end else if (strobe) begin
         code[idx] <= decision;
         if (idx != '0) begin
            code[idx - IW'(1)] <= 1'b1;
            idx                <= idx - IW'(1);
         end
      end
   end

   assign last_c = (idx == '0);

endmodule

// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion sequencer: sample/compare phasing, round-robin channels, timeout abort.
module sar_conv_sequencer
   import sar_pkg::*;
#(
   parameter  int unsigned NUM_BITS       = 4,
   parameter  int unsigned SAMPLE_CYCLES  = 2,
   parameter  int unsigned NUM_CH         = 1,
   parameter  int unsigned TIMEOUT_CYCLES = 16,
   localparam int unsigned CHW            = sel_width(NUM_CH)
) (
   input  logic                clk_external,
   input  logic                reset,
   input  logic                start,
   input  logic                cont,
   input  logic                comp_ready,
   input  logic                comp_out,
   output logic                clk_sample,
   output logic                register_clk,
   output logic                ready,
   output logic                busy,
   output logic [NUM_BITS-1:0] dac_code,
   output logic [CHW-1:0]      ch_sel,
   output logic [NUM_BITS-1:0] sar_code,
   output logic                data_valid,
   output logic [CHW-1:0]      ch_id,
   output logic                err_timeout
);

   localparam int unsigned SW = $clog2(SAMPLE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   if (!params_legal(NUM_BITS, SAMPLE_CYCLES, NUM_CH, TIMEOUT_CYCLES)) begin : g_param_check
      $error("sar_conv_sequencer: illegal parameter set");
   end

   sar_state_t    state, state_next;
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;
   logic          load_init, set_trial, strobe, finish, timeout_hit;
   logic          last_c;
   logic [CHW-1:0] ch_next;

   sar_bit_register #(.NUM_BITS(NUM_BITS)) u_bits (
      .clk       (clk_external),
      .reset     (reset),
      .load_init (load_init),
      .set_trial (set_trial),
      .strobe    (strobe),
      .decision  (comp_out),
      .code      (dac_code),
      .last_c    (last_c)
   );

   // State register.
   always_ff @(posedge clk_external) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and per-cycle control decode.
   always_comb begin
      state_next  = state;
      load_init   = 1'b0;
      set_trial   = 1'b0;
      strobe      = 1'b0;
      finish      = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SAMPLE;
               load_init  = 1'b1;
            end
         end
         SAMPLE: begin
            if (scnt == SW'(SAMPLE_CYCLES - 1)) begin
               state_next = COMPARE;
               set_trial  = 1'b1;
            end
         end
         COMPARE: begin
            // A strobe in the expiring cycle still counts as a decision.
            if (comp_ready) begin
               strobe = 1'b1;
               if (last_c) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 2)) begin
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end
         end
         DONE: begin
            if (cont) begin
               state_next = SAMPLE;
               load_init  = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Sample-phase length and per-bit comparator wait counters.
   always_ff @(posedge clk_external) begin
      if (reset) begin
         scnt <= '0;
         tcnt <= '0;
      end else begin
         scnt <= (state == SAMPLE && state_next == SAMPLE) ? scnt + SW'(1) : '0;
         tcnt <= (state == COMPARE && !strobe && !timeout_hit) ? tcnt + TW'(1) : '0;
      end
   end

   assign ch_next = (ch_sel == CHW'(NUM_CH - 1)) ? '0 : ch_sel + CHW'(1);

   // Registered status strobes, result capture and channel rotation.
   always_ff @(posedge clk_external) begin
      if (reset) begin
         ready        <= 1'b1;
         busy         <= 1'b0;
         clk_sample   <= 1'b0;
         register_clk <= 1'b0;
         data_valid   <= 1'b0;
         err_timeout  <= 1'b0;
         sar_code     <= '0;
         ch_id        <= '0;
         ch_sel       <= '0;
      end else begin
         ready        <= (state_next == IDLE);
         busy         <= (state_next != IDLE);
         clk_sample   <= (state_next == SAMPLE);
         register_clk <= finish;
         data_valid   <= finish;
         err_timeout  <= timeout_hit;
         if (finish) begin
            sar_code <= {dac_code[NUM_BITS-1:1], comp_out};
            ch_id    <= ch_sel;
            ch_sel   <= ch_next;
         end
      end
   end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Self-checking bench for sar_conv_sequencer (4 bits, 3 samples, 3 channels, timeout 16).
module tb_sar_conv_sequencer;

   localparam int S  = 3;
   localparam int NB = 4;
   localparam int NC = 3;

   logic       clk_external = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       comp_ready = 1'b0;
   logic       comp_out = 1'b0;
   logic       clk_sample, register_clk, ready, busy, data_valid, err_timeout;
   logic [3:0] dac_code, sar_code;
   logic [1:0] ch_sel, ch_id;

   int checks = 0;
   int errors = 0;
   int exp_ch = 0;
   int last_code = 0;
   int last_ch = 0;

   sar_conv_sequencer #(
      .NUM_BITS(NB), .SAMPLE_CYCLES(S), .NUM_CH(NC), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_external(clk_external), .reset(reset), .start(start), .cont(cont),
      .comp_ready(comp_ready), .comp_out(comp_out), .clk_sample(clk_sample),
      .register_clk(register_clk), .ready(ready), .busy(busy), .dac_code(dac_code),
      .ch_sel(ch_sel), .sar_code(sar_code), .data_valid(data_valid), .ch_id(ch_id),
      .err_timeout(err_timeout)
   );

   always #5 clk_external = ~clk_external;

   task automatic chk(input string name, input logic [31:0] act, input int expv);
      checks++;
      if (act !== 32'(expv)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Ideal SAR trial for bit b: bits above b taken from vin, bit b set.
   function automatic logic [3:0] trial_of(input int vin, input int b);
      int keep;
      keep = vin & ~((1 << (b + 1)) - 1);
      return 4'(keep | (1 << b));
   endfunction

   function automatic logic [15:0] trials_of(input int vin);
      logic [15:0] tr;
      for (int b = 0; b < NB; b++) tr[b*4 +: 4] = trial_of(vin, b);
      return tr;
   endfunction

   // One conversion, entered at the negedge of the cycle before SAMPLE; returns in the DONE cycle.
   task automatic conv(input int vin, input int wt, input bit do_start, input bit noise,
                       input bit drop_cont, input logic [15:0] trials, input int exp_code);
      logic [3:0] t;
      if (do_start) begin
         chk("ready_before_start", 32'(ready), 1);
         start = 1'b1;
      end
      for (int j = 0; j < S; j++) begin
         @(negedge clk_external);
         if (drop_cont) cont = 1'b0;
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         chk("clk_sample_hi", 32'(clk_sample), 1);
         chk("sample_dac", 32'(dac_code), 0);
         chk("sample_ready", 32'(ready), 0);
         chk("sample_ch_sel", 32'(ch_sel), exp_ch);
      end
      for (int b = NB - 1; b >= 0; b--) begin
         t = trials[b*4 +: 4];
         @(negedge clk_external);
         comp_ready = 1'b0;
         chk("clk_sample_lo", 32'(clk_sample), 0);
         chk("trial", 32'(dac_code), int'(t));
         for (int w = 0; w < wt; w++) begin
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk_external);
            chk("trial_hold", 32'(dac_code), int'(t));
            chk("busy_wait", 32'(busy), 1);
            chk("no_dv_early", 32'(data_valid), 0);
         end
         comp_ready = 1'b1;
         comp_out   = (vin >= int'(t));
      end
      @(negedge clk_external);
      comp_ready = 1'b0;
      comp_out   = 1'b0;
      chk("data_valid", 32'(data_valid), 1);
      chk("register_clk", 32'(register_clk), 1);
      chk("sar_code", 32'(sar_code), exp_code);
      chk("ch_id", 32'(ch_id), exp_ch);
      chk("done_dac", 32'(dac_code), exp_code);
      chk("ch_sel_next", 32'(ch_sel), (exp_ch + 1) % NC);
      last_code = exp_code;
      last_ch   = exp_ch;
      exp_ch    = (exp_ch + 1) % NC;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic expect_idle(input string name);
      @(negedge clk_external);
      start = 1'b0;
      chk({name, "_ready"}, 32'(ready), 1);
      chk({name, "_busy"}, 32'(busy), 0);
      chk({name, "_dv"}, 32'(data_valid), 0);
      chk({name, "_clk_sample"}, 32'(clk_sample), 0);
   endtask

   typedef struct {
      int          vin;
      int          wt;
      bit          noise;
      logic [15:0] trials;
      int          code;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{9,  1,  1'b0, 16'h8CA9, 9};
      vecs[1] = '{0,  1,  1'b0, 16'h8421, 0};
      vecs[2] = '{15, 1,  1'b1, 16'h8CEF, 15};
      vecs[3] = '{5,  0,  1'b1, 16'h8465, 5};
      vecs[4] = '{10, 14, 1'b0, 16'h8CAB, 10};

      repeat (3) @(negedge clk_external);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dac", 32'(dac_code), 0);
      chk("rst_sar", 32'(sar_code), 0);
      chk("rst_ch_sel", 32'(ch_sel), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_clk_sample", 32'(clk_sample), 0);
      reset = 1'b0;
      @(negedge clk_external);

      // Table: explicit trial sequences and results, including a strobe in the expiring cycle.
      for (int i = 0; i < 5; i++) begin
         conv(vecs[i].vin, vecs[i].wt, 1'b1, vecs[i].noise, 1'b0, vecs[i].trials, vecs[i].code);
         expect_idle("tbl_idle");
      end

      // Timeout: decide bits 3 and 2, then withhold the comparator.
      start = 1'b1;
      for (int j = 0; j < S; j++) begin
         @(negedge clk_external);
         start = 1'b0;
      end
      @(negedge clk_external);
      chk("to_trial3", 32'(dac_code), 8);
      comp_ready = 1'b1;
      comp_out   = 1'b1;
      @(negedge clk_external);
      chk("to_trial2", 32'(dac_code), 12);
      comp_out = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk_external);
         comp_ready = 1'b0;
         chk("to_no_err", 32'(err_timeout), 0);
         chk("to_busy", 32'(busy), 1);
         chk("to_no_dv", 32'(data_valid), 0);
      end
      @(negedge clk_external);
      chk("to_err_pulse", 32'(err_timeout), 1);
      chk("to_no_dv_at_err", 32'(data_valid), 0);
      @(negedge clk_external);
      chk("to_ready", 32'(ready), 1);
      chk("to_err_single", 32'(err_timeout), 0);
      chk("to_sar_kept", 32'(sar_code), last_code);
      chk("to_ch_id_kept", 32'(ch_id), last_ch);
      chk("to_ch_sel_kept", 32'(ch_sel), exp_ch);

      // Reset in the middle of COMPARE discards everything.
      start = 1'b1;
      for (int j = 0; j < S; j++) begin
         @(negedge clk_external);
         start = 1'b0;
      end
      @(negedge clk_external);
      comp_ready = 1'b1;
      comp_out   = 1'b1;
      @(negedge clk_external);
      comp_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk_external);
      chk("mid_rst_ready", 32'(ready), 1);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_dac", 32'(dac_code), 0);
      chk("mid_rst_sar", 32'(sar_code), 0);
      chk("mid_rst_ch_sel", 32'(ch_sel), 0);
      reset  = 1'b0;
      exp_ch = 0;

      // Continuous mode across three channels, cont dropped during the fourth conversion.
      cont = 1'b1;
      conv(3,  1, 1'b1, 1'b0, 1'b0, trials_of(3),  3);
      conv(7,  2, 1'b0, 1'b0, 1'b0, trials_of(7),  7);
      conv(12, 1, 1'b0, 1'b0, 1'b0, trials_of(12), 12);
      conv(3,  0, 1'b0, 1'b0, 1'b1, trials_of(3),  3);
      expect_idle("cont_end_idle");

      // Random conversions against the ideal-SAR model.
      for (int r = 0; r < 30; r++) begin
         int v;
         v = int'($urandom_range(0, 15));
         conv(v, int'($urandom_range(0, 14)), 1'b1, 1'($urandom_range(0, 1)), 1'b0,
              trials_of(v), v);
         expect_idle("rnd_idle");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
